// File: rtl/risc16_pkg.sv
// ---------------------------------------------------------------------------
// risc16_pkg
// Shared definitions for the RISC16 data-memory arbiter slice.
//   RISC16_AW / RISC16_DW : default address and data widths (256 x 16 RAM)
//   master_e              : requester index, M_CORE = 0 (load/store port),
//                           M_HOST = 1 (host/loader port)
// ---------------------------------------------------------------------------
package risc16_pkg;

  localparam int RISC16_AW = 8;
  localparam int RISC16_DW = 16;

  // Requester index; also the encoding stored in the grant/response history.
  typedef enum logic {
    M_CORE = 1'b0,
    M_HOST = 1'b1
  } master_e;

endpackage

// File: rtl/risc16_mem_arb_if.sv
// ---------------------------------------------------------------------------
// risc16_mem_arb_if
// One requester port of the data-memory arbiter.
//   valid/ready      : request handshake, transfer when both are high
//   we/addr/wdata    : access description, held stable by the requester
//                      until ready
//   rvalid/rdata     : read response, one cycle after the granted read
// Modports:
//   master : requester side (core or host)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface risc16_mem_arb_if
  import risc16_pkg::*;
#(
  parameter int AW = RISC16_AW,
  parameter int DW = RISC16_DW
) ();

  logic          valid;
  logic          ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/risc16_rr_pick.sv
// ---------------------------------------------------------------------------
// risc16_rr_pick
// Combinational two-way grant picker.
//   valid[1:0]  : request vector, bit N = master N requesting
//   last_grant  : master granted most recently
//   prio_mode   : 0 = round-robin, 1 = master 0 fixed priority
//   force_m1    : in priority mode, master 1 has starved and must win
//   grant[1:0]  : one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module risc16_rr_pick
  import risc16_pkg::*;
(
  input  logic [1:0] valid,
  input  master_e    last_grant,
  input  logic       prio_mode,
  input  logic       force_m1,
  output logic [1:0] grant
);

  // A lone requester always wins. On contention, round-robin hands the
  // slot to whoever did not win last; priority mode favours the core
  // unless the starvation guard has tripped.
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (prio_mode) begin
          grant = force_m1 ? 2'b10 : 2'b01;
        end else begin
          grant = (last_grant == M_HOST) ? 2'b01 : 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/risc16_mem_arb.sv
// ---------------------------------------------------------------------------
// risc16_mem_arb
// Shares the single-port data RAM between the core load/store port (m0)
// and the host/loader port (m1). At most one access is granted per cycle;
// read data comes back to the winner one cycle later.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   m0, m1          : requester ports (risc16_mem_arb_if.slave)
//   mem_en/mem_we   : RAM access strobe and write enable
//   mem_addr        : RAM word address
//   mem_wdata       : RAM write data
//   mem_rdata       : RAM registered read data
// Parameters:
//   AW, DW          : address / data widths
//   PRIO_M0         : 0 = round-robin, 1 = m0 priority with starvation guard
//   STARVE_MAX      : consecutive m1 losses before m1 is forced (1..15)
// ---------------------------------------------------------------------------
module risc16_mem_arb
  import risc16_pkg::*;
#(
  parameter int AW         = RISC16_AW,
  parameter int DW         = RISC16_DW,
  parameter int PRIO_M0    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  risc16_mem_arb_if.slave m0,
  risc16_mem_arb_if.slave m1,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic       PRIO_MODE  = (PRIO_M0 != 0);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  master_e    last_grant_q, last_grant_d;
  master_e    rsp_owner_q,  rsp_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_pend_q,   rsp_pend_d;

  logic [1:0] req_valid;
  logic [1:0] pick_grant;
  logic [1:0] grant;
  logic       force_m1;

  assign req_valid = {m1.valid, m0.valid};
  assign force_m1  = (starve_cnt_q == STARVE_LIM);

  risc16_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .prio_mode  (PRIO_MODE),
    .force_m1   (force_m1),
    .grant      (pick_grant)
  );

  // The grant path is combinational, so it is gated with rst_n to keep
  // ready and mem_en low for the whole time reset is asserted.
  assign grant    = pick_grant & {2{rst_n}};
  assign m0.ready = grant[0];
  assign m1.ready = grant[1];

  // RAM request mux: steer the winner onto the RAM bus, park it at zero
  // when idle so the bus does not echo stale requester values.
  always_comb begin
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[0]) begin
      mem_we    = m0.we;
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
    end else if (grant[1]) begin
      mem_we    = m1.we;
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
    end
  end

  // Next-state for arbitration history and response tracking. The
  // starvation counter only runs while m1 is actually waiting and
  // saturates so the forced grant stays asserted until m1 wins.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_owner_d  = rsp_owner_q;
    if (grant[0]) begin
      last_grant_d = M_CORE;
      rsp_owner_d  = M_CORE;
    end else if (grant[1]) begin
      last_grant_d = M_HOST;
      rsp_owner_d  = M_HOST;
    end

    rsp_pend_d = (|grant) && !mem_we;

    starve_cnt_d = 4'd0;
    if (m1.valid && !grant[1]) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                  : starve_cnt_q + 4'd1;
    end
  end

  // State registers. Reset makes m1 the "last" winner so the core takes
  // the first round-robin contention, and drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= M_HOST;
      rsp_owner_q  <= M_CORE;
      starve_cnt_q <= 4'd0;
      rsp_pend_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_owner_q  <= rsp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
    end
  end

  // Read response routing: RAM data goes to the owner of the previous
  // cycle's read, the other port sees zero.
  assign m0.rvalid = rsp_pend_q && (rsp_owner_q == M_CORE);
  assign m1.rvalid = rsp_pend_q && (rsp_owner_q == M_HOST);
  assign m0.rdata  = (rsp_owner_q == M_CORE) ? mem_rdata : '0;
  assign m1.rdata  = (rsp_owner_q == M_HOST) ? mem_rdata : '0;

endmodule

// File: doc/risc16_mem_arb.md
Name: risc16_mem_arb

Overview:
Two-requester arbiter that shares the single-port 256x16 data RAM between the RISC16 core's load/store port (m0) and a host/loader port (m1). The host port preloads data, inspects results and pokes memory while the core runs. It sits between both requesters and the RAM macro. It grants at most one access per cycle, and returns read data to the winning requester one cycle later.

Parameters:
AW, 8, address width; RAM depth is 2**AW words.
DW, 16, data word width.
PRIO_M0, 0, 0 = round-robin; 1 = m0 fixed priority with an m1 starvation guard.
STARVE_MAX, 4, in PRIO_M0=1 mode, number of consecutive cycles m1 can lose before it is force-granted; range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
m0_valid  in  1  core requests an access.
m0_ready  out  1  m0 access accepted this cycle.
m0_we  in  1  1 = write, 0 = read.
m0_addr  in  AW  word address.
m0_wdata  in  DW  write data.
m0_rvalid  out  1  read data valid for m0.
m0_rdata  out  DW  read data for m0.
m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata  same directions, widths and meanings as the m0 ports, for the host port.
mem_en  out  1  RAM access strobe.
mem_we  out  1  RAM write enable.
mem_addr  out  AW  RAM address.
mem_wdata  out  DW  RAM write data.
mem_rdata  in  DW  RAM read data, registered by the RAM; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values of state: last_grant=1, so m0 wins the first contention in round-robin mode; starve_cnt=0; rsp_pend=0; rsp_owner=0.
- Reset values of outputs: m0_rvalid=m1_rvalid=0; ready outputs and mem_en are 0 while rst_n=0.
- Grant logic is combinational from the valid inputs and registered state:
  - Only one valid: grant that master.
  - Both valid, PRIO_M0=0: grant the master that is not last_grant.
  - Both valid, PRIO_M0=1: grant m0 unless starve_cnt==STARVE_MAX, in which case grant m1.
- mN_ready = granted master. mem_en = any grant. mem_we, mem_addr and mem_wdata are muxed from the granted master. When nothing is granted, mem_we=0 and mem_addr/mem_wdata=0.
- Handshake:
  - A transfer occurs when valid&&ready.
  - A requester holds valid, we, addr and wdata stable until ready.
  - The arbiter never asserts ready without valid.
  - There is no back-to-back restriction: one access per cycle, full throughput.
- Registered state on each rising edge:
  - last_grant <= granted master, if any grant.
  - starve_cnt: if m1_valid && !m1_ready, increment, saturating at STARVE_MAX; otherwise reset to 0.
  - rsp_pend <= grant && !mem_we.
  - rsp_owner <= granted master.
- Read response:
  - Read latency is exactly 1 cycle: mN_rvalid = rsp_pend && rsp_owner==N.
  - mN_rdata = mem_rdata for the owner; the non-owner's rdata is 0.
  - Writes produce no response.
- Simultaneous events:
  - A read granted in cycle T and a new grant in cycle T+1 overlap legally. The response for T and the address for T+1 share cycle T+1.
  - A write and a read to the same address in consecutive cycles: the read returns the new data, which is the RAM's behaviour; the arbiter adds no forwarding.
- Reset mid-operation: a pending read response is dropped (rvalid forced 0) and arbitration history is cleared.
- Address width: mem_addr is exactly AW bits; there is no address translation or wrap logic. Address 2**AW-1 is legal.

Decomposition:
- Shared package risc16_pkg: AW and DW defaults, and the master-index constants M_CORE=0 and M_HOST=1.
- One natural sub-module: risc16_rr_pick. It is the combinational 2-way picker taking valid[1:0], last_grant, prio_mode and force_m1, and returning the grant vector.
- Counters and response tracking stay in the top level.

Test Plan:
1. Reset, then m0 alone writes 0x1234 to addr 0x05. Next cycle m0 reads 0x05 -> m0_ready=1 both cycles, mem_we=1 then 0; m0_rvalid=1 with m0_rdata=0x1234 on the cycle after the read; m1_rvalid stays 0.
2. PRIO_M0=0, both requesters hold valid reads for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1, starting with m0; each rvalid follows its grant by one cycle to the correct owner.
3. PRIO_M0=1, STARVE_MAX=4, both continuously valid -> m0 granted 4 cycles, m1 granted on the 5th, starve_cnt returns to 0, and the pattern repeats.
4. m1 writes 0xBEEF to 0xFF while m0 is idle, then m0 reads 0xFF -> m0_rdata=0xBEEF; address 0xFF is handled with no wrap error.
5. m0 read granted, then rst_n dropped asynchronously mid-cycle before the response edge -> m0_rvalid never asserts. After release, the first contention goes to m0.
6. Requester holds valid while the other is granted -> its addr/wdata stay stable, it is accepted exactly once, and mem_en is never asserted on a cycle with no valid input.
